// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: shared widths and recovery FSM state encoding
package branch_redirect_ctrl_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int DRAIN_W = 3;
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        DRAIN    = 2'b10
    } state_t;
endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: flush, redirect handshake and stale-fetch drain after an EX mispredict
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int FETCH_LAT  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic                  ex_taken,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic [ADDR_WIDTH-1:0] ex_pc_plus4,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  hold_pipe,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);
    state_t             state, state_nx;
    logic [DRAIN_W-1:0] drain, drain_nx;
    logic               mis, accept;

    assign mis            = ex_valid & ~ex_stall & (ex_taken != ex_pred_taken);
    assign accept         = redirect_valid & redirect_ready;
    assign redirect_valid = state == REDIRECT;
    assign hold_pipe      = state == REDIRECT;
    assign flush_id_ex    = (state == IDLE && mis) || state == REDIRECT;
    assign flush_if_id    = flush_id_ex || state == DRAIN;

    // mis outside IDLE cannot happen (EX is flushed), so only IDLE looks at it
    always_comb begin
        state_nx = state;
        drain_nx = drain;
        case (state)
            IDLE:     state_nx = mis ? REDIRECT : IDLE;
            REDIRECT: if (accept) begin
                state_nx = (FETCH_LAT == 0) ? IDLE : DRAIN;
                drain_nx = DRAIN_W'(FETCH_LAT);
            end
            DRAIN: begin
                drain_nx = drain - 1'b1;
                state_nx = (drain == DRAIN_W'(1)) ? IDLE : DRAIN;
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            drain       <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_nx;
            drain <= drain_nx;
            if (state == IDLE && mis) redirect_pc <= ex_taken ? ex_target : ex_pc_plus4;
        end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .count (mispredict_cnt)
    );
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed checks of recovery sequencing across four parameter builds
module tb_branch_redirect_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        ex_valid = 0, ex_stall = 0, ex_taken = 0, ex_pred_taken = 0, redirect_ready = 0;
    logic [31:0] ex_target = 0, ex_pc_plus4 = 0;
    logic        rv1, fi1, fe1, hp1, rv4, fi4, fe4, hp4, rv0, fi0, fe0, hp0, rv3, fi3, fe3, hp3;
    logic [31:0] pc1, pc4, pc0, pc3;
    logic [15:0] cnt1, cnt0, cnt3;
    logic [3:0]  cnt4;
    int          checks = 0, passes = 0;
    int          exp_cnt = 0;
    logic [3:0]  exp_cnt4 = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
        .redirect_valid(rv1), .redirect_pc(pc1), .redirect_ready(redirect_ready),
        .flush_if_id(fi1), .flush_id_ex(fe1), .hold_pipe(hp1), .mispredict_cnt(cnt1));
    branch_redirect_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
        .redirect_valid(rv4), .redirect_pc(pc4), .redirect_ready(redirect_ready),
        .flush_if_id(fi4), .flush_id_ex(fe4), .hold_pipe(hp4), .mispredict_cnt(cnt4));
    branch_redirect_ctrl #(.FETCH_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
        .redirect_valid(rv0), .redirect_pc(pc0), .redirect_ready(redirect_ready),
        .flush_if_id(fi0), .flush_id_ex(fe0), .hold_pipe(hp0), .mispredict_cnt(cnt0));
    branch_redirect_ctrl #(.FETCH_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
        .redirect_valid(rv3), .redirect_pc(pc3), .redirect_ready(redirect_ready),
        .flush_if_id(fi3), .flush_id_ex(fe3), .hold_pipe(hp3), .mispredict_cnt(cnt3));

    // A mismatch reaching EX while any build is still recovering is a pipeline bug
    wire mis  = ex_valid & ~ex_stall & (ex_taken != ex_pred_taken);
    wire busy = hp1 | (fi1 & ~fe1) | hp0 | hp3 | (fi3 & ~fe3) | hp4 | (fi4 & ~fe4);
    always @(posedge clk)
        if (rst_n && mis && busy) $error("assertion: mispredict while not IDLE");

    task tick;
        @(posedge clk);
        #1;
    endtask

    task bubble;
        ex_valid = 0; ex_stall = 0; ex_taken = 0; ex_pred_taken = 0;
    endtask

    task idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bubble();
        end
    endtask

    task test_reset;
        @(negedge clk);
        checks++; if ({rv1, fi1, fe1, hp1} !== 4'b0) $display("FAIL reset_outs act=%b exp=0000", {rv1, fi1, fe1, hp1}); else passes++;
        checks++; if (pc1 !== 32'h0) $display("FAIL reset_pc act=%h exp=0", pc1); else passes++;
        checks++; if (cnt1 !== 16'h0) $display("FAIL reset_cnt act=%0d exp=0", cnt1); else passes++;
        rst_n = 1;
        idle_cycles(2);
        @(negedge clk);
        checks++; if ({rv1, fi1, hp1, rv3, fi3} !== 5'b0) $display("FAIL post_reset_idle act=%b exp=00000", {rv1, fi1, hp1, rv3, fi3}); else passes++;
    endtask

    task test_not_taken_mispredict;
        tick();
        ex_valid = 1; ex_taken = 1; ex_pred_taken = 0; ex_target = 32'h100; ex_pc_plus4 = 32'h8; redirect_ready = 1;
        @(negedge clk);
        checks++; if ({fi1, fe1, rv1, hp1} !== 4'b1100) $display("FAIL nt_t_flush act=%b exp=1100", {fi1, fe1, rv1, hp1}); else passes++;
        tick();
        bubble();
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b1111) $display("FAIL nt_t1_redirect act=%b exp=1111", {rv1, hp1, fi1, fe1}); else passes++;
        checks++; if (pc1 !== 32'h100) $display("FAIL nt_t1_pc act=%h exp=100", pc1); else passes++;
        exp_cnt++; exp_cnt4++;
        tick();
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b0010) $display("FAIL nt_t2_drain act=%b exp=0010", {rv1, hp1, fi1, fe1}); else passes++;
        checks++; if (cnt1 !== 16'(exp_cnt)) $display("FAIL nt_cnt act=%0d exp=%0d", cnt1, exp_cnt); else passes++;
        tick();
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b0000) $display("FAIL nt_t3_idle act=%b exp=0000", {rv1, hp1, fi1, fe1}); else passes++;
        idle_cycles(3);
    endtask

    task test_backpressure;
        tick();
        ex_valid = 1; ex_taken = 0; ex_pred_taken = 1; ex_pc_plus4 = 32'h44; ex_target = 32'h200; redirect_ready = 0;
        tick();
        bubble();
        for (int i = 0; i < 4; i++) begin
            ex_target = 32'h300 + 32'(i);
            if (i == 3) redirect_ready = 1;
            @(negedge clk);
            checks++; if ({rv1, hp1, fi1, fe1} !== 4'b1111) $display("FAIL bp_hold[%0d] act=%b exp=1111", i, {rv1, hp1, fi1, fe1}); else passes++;
            checks++; if (pc1 !== 32'h44) $display("FAIL bp_pc[%0d] act=%h exp=44", i, pc1); else passes++;
            tick();
        end
        exp_cnt++; exp_cnt4++;
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b0010) $display("FAIL bp_drain act=%b exp=0010", {rv1, hp1, fi1, fe1}); else passes++;
        checks++; if (cnt1 !== 16'(exp_cnt)) $display("FAIL bp_cnt act=%0d exp=%0d", cnt1, exp_cnt); else passes++;
        idle_cycles(5);
    endtask

    task test_no_action;
        tick();
        ex_valid = 1; ex_taken = 1; ex_pred_taken = 1; ex_target = 32'h500; redirect_ready = 1;
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b0000) $display("FAIL correct_taken act=%b exp=0000", {rv1, hp1, fi1, fe1}); else passes++;
        tick();
        ex_pred_taken = 0; ex_stall = 1;
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b0000) $display("FAIL stalled_mis act=%b exp=0000", {rv1, hp1, fi1, fe1}); else passes++;
        tick();
        bubble();
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1} !== 3'b000) $display("FAIL stall_stays_idle act=%b exp=000", {rv1, hp1, fi1}); else passes++;
        checks++; if (cnt1 !== 16'(exp_cnt)) $display("FAIL no_action_cnt act=%0d exp=%0d", cnt1, exp_cnt); else passes++;
    endtask

    task test_reset_mid_redirect;
        tick();
        ex_valid = 1; ex_taken = 1; ex_pred_taken = 0; ex_target = 32'h700; redirect_ready = 0;
        tick();
        bubble();
        @(negedge clk);
        checks++; if (rv1 !== 1'b1) $display("FAIL rst_pending act=%b exp=1", rv1); else passes++;
        #2 rst_n = 0;
        #1;
        checks++; if ({rv1, hp1, fi1, fe1} !== 4'b0000) $display("FAIL rst_async act=%b exp=0000", {rv1, hp1, fi1, fe1}); else passes++;
        checks++; if (cnt1 !== 16'h0) $display("FAIL rst_cnt act=%0d exp=0", cnt1); else passes++;
        exp_cnt = 0; exp_cnt4 = 0;
        redirect_ready = 1;
        @(negedge clk);
        rst_n = 1;
        idle_cycles(2);
        @(negedge clk);
        checks++; if ({rv1, hp1, fi1, pc1} !== {3'b000, 32'h0}) $display("FAIL rst_release act=%b/%h exp=000/0", {rv1, hp1, fi1}, pc1); else passes++;
    endtask

    task test_saturation;
        for (int n = 1; n <= 17; n++) begin
            tick();
            ex_valid = 1; ex_taken = n[0]; ex_pred_taken = ~n[0]; ex_target = 32'h1000; ex_pc_plus4 = 32'h2000; redirect_ready = 1;
            idle_cycles(6);
            exp_cnt++;
            if (exp_cnt4 != 4'hF) exp_cnt4++;
            if (n == 15 || n == 17) begin
                @(negedge clk);
                checks++; if (cnt4 !== exp_cnt4) $display("FAIL sat_cnt4[%0d] act=%h exp=%h", n, cnt4, exp_cnt4); else passes++;
            end
        end
        @(negedge clk);
        checks++; if (cnt1 !== 16'(exp_cnt)) $display("FAIL sat_cnt16 act=%0d exp=%0d", cnt1, exp_cnt); else passes++;
        checks++; if (pc3 !== 32'h1000) $display("FAIL sat_last_pc act=%h exp=1000", pc3); else passes++;
    endtask

    task test_fetch_lat;
        int d0, d1, d3;
        tick();
        ex_valid = 1; ex_taken = 0; ex_pred_taken = 1; ex_pc_plus4 = 32'h80; redirect_ready = 1;
        tick();
        bubble();
        d0 = 0; d1 = 0; d3 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++; if ({rv0, fi0, hp0} !== 3'b000) $display("FAIL lat0_idle act=%b exp=000", {rv0, fi0, hp0}); else passes++;
            end
            d0 += int'(fi0 & ~fe0);
            d1 += int'(fi1 & ~fe1);
            d3 += int'(fi3 & ~fe3);
            tick();
        end
        checks++; if (d0 !== 0) $display("FAIL lat0_drain act=%0d exp=0", d0); else passes++;
        checks++; if (d1 !== 1) $display("FAIL lat1_drain act=%0d exp=1", d1); else passes++;
        checks++; if (d3 !== 3) $display("FAIL lat3_drain act=%0d exp=3", d3); else passes++;
        checks++; if (pc0 !== 32'h80) $display("FAIL lat0_pc act=%h exp=80", pc0); else passes++;
    endtask

    initial begin
        test_reset();
        test_not_taken_mispredict();
        test_backpressure();
        test_no_action();
        test_reset_mid_redirect();
        test_saturation();
        test_fetch_lat();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences recovery after a resolved control-flow instruction in EX.
- Compares the EX-stage taken decision (conditional-branch result OR jal) against the fetch-time static prediction.
- On mismatch: flushes IF/ID and ID/EX, holds a PC redirect to the fetch unit under a valid/ready handshake, then drains stale in-flight fetches before resuming.
- Sits between EX (branch decision) and IF (PC generation / instruction memory).

Parameters:
ADDR_WIDTH, 32, width of PC/target buses (equals `DATA_WIDTH)
FETCH_LAT, 1, instruction-memory read latency in cycles; stale words to discard after redirect (0..7)
CNT_WIDTH, 16, width of saturating mispredict counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a valid instruction
ex_stall  in  1  EX not advancing this cycle
ex_taken  in  1  resolved decision from branch logic (branch taken or jal)
ex_pred_taken  in  1  prediction made at fetch for this instruction
ex_target  in  ADDR_WIDTH  taken target
ex_pc_plus4  in  ADDR_WIDTH  fall-through PC
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  ADDR_WIDTH  corrected PC, stable while redirect_valid
redirect_ready  in  1  fetch accepts redirect
flush_if_id  out  1  clear IF/ID at next edge
flush_id_ex  out  1  clear ID/EX at next edge
hold_pipe  out  1  freeze PC and IF/ID while recovery in progress
mispredict_cnt  out  CNT_WIDTH  accepted redirects, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; redirect_valid=0, redirect_pc=0, flush_*=0, hold_pipe=0, mispredict_cnt=0, drain counter=0. Reset mid-operation abandons any pending redirect.
- Detection: mis = ex_valid & ~ex_stall & (ex_taken != ex_pred_taken). Corrected PC = ex_taken ? ex_target : ex_pc_plus4.
- States: IDLE, REDIRECT, DRAIN.
- IDLE:
  - flush_if_id = flush_id_ex = mis, combinational, same cycle t; wrong-path instructions clear at the t→t+1 edge.
  - On mis: capture corrected PC into redirect_pc; go to REDIRECT. redirect_valid=1 from cycle t+1 (registered).
  - No mis, including a stalled EX (ex_stall=1): outputs 0; stay IDLE.
- REDIRECT:
  - redirect_valid=1, hold_pipe=1, flush_if_id=1, flush_id_ex=1.
  - redirect_pc held constant.
  - On redirect_valid & redirect_ready:
    - increment mispredict_cnt, saturating at all-ones;
    - go to DRAIN with drain counter=FETCH_LAT, or to IDLE if FETCH_LAT=0.
  - redirect_valid deasserts the cycle after acceptance.
- DRAIN:
  - flush_if_id=1, hold_pipe=0, redirect_valid=0, flush_id_ex=0.
  - Counter decrements each cycle; at 1 go to IDLE. Exactly FETCH_LAT cycles in DRAIN.
- Events outside IDLE:
  - Any mis while in REDIRECT or DRAIN is ignored. Flushes guarantee EX is a bubble, so this must not occur.
  - The bench flags it as an assertion failure.
- ex_taken=1 with ex_pred_taken=1: no action, even for jal. A correctly predicted taken instruction costs zero cycles here.
- redirect_ready while redirect_valid=0 has no effect.
- Counter width arithmetic: unsigned CNT_WIDTH, no wrap.

Decomposition:
- Shared include (alongside `DATA_WIDTH):
  - state encoding defines: IDLE=2'b00, REDIRECT=2'b01, DRAIN=2'b10;
  - width define for the drain counter (3 bits).
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count) for mispredict_cnt. Reusable for other performance counters.
- FSM, capture register and drain counter live in branch_redirect_ctrl.

Test Plan:
- Not-taken mispredict: ex_valid=1, ex_taken=1, ex_pred_taken=0, ex_target=0x0000_0100, redirect_ready=1 at t+1 -> flush_* high at t; redirect_valid high at t+1 only with redirect_pc=0x100; flush_if_id high at t+2 (DRAIN, FETCH_LAT=1); IDLE at t+3; mispredict_cnt=1.
- Taken mispredict with backpressure: ex_taken=0, ex_pred_taken=1, ex_pc_plus4=0x0000_0044, redirect_ready low 3 cycles -> redirect_valid, hold_pipe and flush_* held 4 cycles; redirect_pc stays 0x44 even though ex_target changes.
- Correct prediction / stall: ex_taken=ex_pred_taken=1, then a mismatch with ex_stall=1 -> all outputs 0, state IDLE, counter unchanged.
- Reset mid-REDIRECT: drop rst_n during a pending redirect -> redirect_valid, hold_pipe and flush_* go 0 immediately (async). After release: IDLE, counter 0.
- Saturation: CNT_WIDTH=4, 17 accepted mispredicts -> mispredict_cnt=4'hF, stays 4'hF.
- FETCH_LAT=0 and FETCH_LAT=3 builds: after acceptance, DRAIN lasts 0 and 3 cycles respectively (flush_if_id pulse width checked).
